insmem_loader: RTL and testbench

INSMEM_LOADER -- requirements
Module: insmem_loader

---
 rtl/insmem_loader.sv | 163 ++++++++++++++++
 tb/tb_insmem_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/insmem_loader.sv
// rtl/insmem_loader.sv - instruction memory with byte-serial loader and direct word write port
// Optional: INSMEM_CLEAR_ON_RESET_EN clears all memory asynchronously on reset_n low.
module insmem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_start,
  input  logic [7:0]       load_byte,
  input  logic             load_valid,
  input  logic             load_end,
  input  logic             write_en,
  input  logic [31:0]      addr_wr,
  input  logic [31:0]      data,
  input  logic             read_en,
  input  logic [31:0]      addr,
  output logic [31:0]      instruction,
  output logic             addr_err,
  output logic             load_busy,
  output logic             load_done,
  output logic             load_ovf,
  output logic [CNT_W-1:0] load_words
);

  localparam int WN = DEPTH / 4;
  localparam int WA = $clog2(WN);
  localparam int PW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [1:0]         lane_q, lane_d;
  logic [23:0]        hold_q, hold_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               wr_en;
  logic [WA-1:0]      wr_idx;
  logic [31:0]        wr_data;
  logic               direct_ok;

  logic [31:0]        mem [WN];

  assign direct_ok = write_en && (addr_wr[1:0] == 2'b00) && (addr_wr <= 32'(DEPTH - 4));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lane_d  = lane_q;
    hold_d  = hold_q;
    words_d = words_q;
    ovf_d   = ovf_q;
    done_d  = (state_q == S_FLUSH);
    wr_en   = 1'b0;
    wr_idx  = ptr_q[WA+1:2];
    wr_data = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          lane_d  = 2'd0;
          hold_d  = 24'h0;
          words_d = '0;
          ovf_d   = 1'b0;
        end else if (direct_ok) begin
          wr_en   = 1'b1;
          wr_idx  = addr_wr[WA+1:2];
          wr_data = data;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          ptr_d   = '0;
          lane_d  = 2'd0;
          hold_d  = 24'h0;
          words_d = '0;
          ovf_d   = 1'b0;
        end else begin
          // A coincident load_end still lets this cycle's byte in before flushing.
          if (load_valid) begin
            if (ptr_q[PW-1]) begin
              ovf_d = 1'b1;
            end else if (lane_q == 2'd3) begin
              wr_en   = 1'b1;
              wr_data = {load_byte, hold_q};
              ptr_d   = ptr_q + PW'(4);
              lane_d  = 2'd0;
              hold_d  = 24'h0;
              words_d = words_q + CNT_W'(1);
            end else begin
              case (lane_q)
                2'd0:    hold_d[7:0]   = load_byte;
                2'd1:    hold_d[15:8]  = load_byte;
                default: hold_d[23:16] = load_byte;
              endcase
              lane_d = lane_q + 2'd1;
            end
          end
          if (load_end) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = S_IDLE;
        // Unheld lanes of hold_q are already zero, giving the upper-byte padding.
        if (lane_q != 2'd0) begin
          wr_en   = 1'b1;
          wr_data = {8'h00, hold_q};
          ptr_d   = ptr_q + PW'(4);
          lane_d  = 2'd0;
          hold_d  = 24'h0;
          words_d = words_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      lane_q  <= 2'd0;
      hold_q  <= 24'h0;
      words_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
      words_q <= words_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

`ifdef INSMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WN; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end
`endif

  assign addr_err    = read_en && ((addr[1:0] != 2'b00) || (addr > 32'(DEPTH - 4)));
  assign instruction = (read_en && !addr_err) ? mem[addr[WA+1:2]] : 32'h0;
  assign load_busy   = (state_q != S_IDLE);
  assign load_done   = done_q;
  assign load_ovf    = ovf_q;
  assign load_words  = words_q;

endmodule

// File: tb/tb_insmem_loader.sv
// tb/tb_insmem_loader.sv - directed self-checking bench for insmem_loader
module tb_insmem_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             load_start = 1'b0;
  logic [7:0]       load_byte = 8'h0;
  logic             load_valid = 1'b0;
  logic             load_end = 1'b0;
  logic             write_en = 1'b0;
  logic [31:0]      addr_wr = 32'h0;
  logic [31:0]      data = 32'h0;
  logic             read_en = 1'b0;
  logic [31:0]      addr = 32'h0;
  logic [31:0]      instruction;
  logic             addr_err;
  logic             load_busy;
  logic             load_done;
  logic             load_ovf;
  logic [CNT_W-1:0] load_words;

  int checks = 0;
  int errors = 0;

  insmem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid), .load_end(load_end),
    .write_en(write_en), .addr_wr(addr_wr), .data(data),
    .read_en(read_en), .addr(addr), .instruction(instruction), .addr_err(addr_err),
    .load_busy(load_busy), .load_done(load_done), .load_ovf(load_ovf), .load_words(load_words)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
    read_en = 1'b1;
    addr    = a;
    #1;
    check(tag, instruction, exp);
    read_en = 1'b0;
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic end_load;
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_busy", load_busy, 0);
    check("rst_done", load_done, 0);
    check("rst_ovf", load_ovf, 0);
    check("rst_words", load_words, 0);
    reset_n = 1'b1;
    tick();

    // Four bytes form one word, visible on the edge that writes it
    start_load();
    check("busy_in_load", load_busy, 1);
    send(8'h13); send(8'h00); send(8'h08); send(8'h20);
    check_word("w0_zero_latency", 32'h0, 32'h2008_0013);
    end_load();
    check("flush_busy", load_busy, 1);
    check("flush_no_done", load_done, 0);
    tick();
    check("done_pulse", load_done, 1);
    check("idle_not_busy", load_busy, 0);
    check("words_1", load_words, 1);
    tick();
    check("done_one_cycle", load_done, 0);

    // Six bytes: one full word plus a zero-padded partial word
    start_load();
    for (int i = 1; i <= 6; i++) send(8'(i));
    end_load();
    tick();
    check_word("w0_six", 32'h0, 32'h0403_0201);
    check_word("w4_partial", 32'h4, 32'h0000_0605);
    check("words_2", load_words, 2);

    // Third byte coincides with load_end: byte accepted, then flushed padded
    start_load();
    send(8'hAA); send(8'hBB);
    load_end = 1'b1;
    send(8'hCC);
    load_end = 1'b0;
    tick();
    check_word("w0_coincide", 32'h0, 32'h00CC_BBAA);
    check("words_coincide", load_words, 1);

    // Read address errors
    read_en = 1'b1; addr = 32'h2; #1;
    check("err_misalign", addr_err, 1);
    check("instr_misalign", instruction, 32'h0);
    addr = 32'(DEPTH); #1;
    check("err_depth", addr_err, 1);
    addr = 32'(DEPTH - 4); #1;
    check("err_last_ok", addr_err, 0);
    read_en = 1'b0; addr = 32'h2; #1;
    check("err_no_read", addr_err, 0);
    check("instr_no_read", instruction, 32'h0);
    tick();

    // Direct word write in IDLE; misaligned write ignored
    write_en = 1'b1; addr_wr = 32'h8; data = 32'hDEAD_BEEF;
    tick();
    addr_wr = 32'h9; data = 32'h1234_5678;
    tick();
    write_en = 1'b0;
    check_word("direct_w8", 32'h8, 32'hDEAD_BEEF);
    tick();

    // Overflow: DEPTH+4 bytes fill memory then get dropped
    start_load();
    for (int i = 0; i < DEPTH + 4; i++) send(8'(i + 1));
    check("ovf_set", load_ovf, 1);
    check("ovf_words", load_words, DEPTH / 4);
    end_load();
    tick();
    check("ovf_sticky", load_ovf, 1);
    check_word("ovf_w0_kept", 32'h0, 32'h0403_0201);
    check_word("ovf_last", 32'(DEPTH - 4), 32'h201F_1E1D);
    tick();

    // New load clears ovf; restart in LOAD discards held bytes
    start_load();
    check("start_clr_ovf", load_ovf, 0);
    check("start_clr_words", load_words, 0);
    send(8'h11); send(8'h22);
    start_load();
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    check_word("restart_w0", 32'h0, 32'h8877_6655);
    end_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("flush_start_ignored", load_busy, 0);
    check("restart_words", load_words, 1);
    tick();

    // Reset in mid-load aborts immediately without writing the partial word
    start_load();
    send(8'hAA); send(8'hBB);
    check("busy_before_rst", load_busy, 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_busy", load_busy, 0);
    check("rst_async_words", load_words, 0);
    check("rst_async_ovf", load_ovf, 0);
    tick();
    reset_n = 1'b1;
    tick();
`ifdef INSMEM_CLEAR_ON_RESET_EN
    check_word("rst_w0", 32'h0, 32'h0);
`else
    check_word("rst_w0", 32'h0, 32'h8877_6655);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
